// File: rtl/bitty_regfile_seq.sv
// BittyPro register file and three-phase instruction sequencer (IDLE -> EXEC -> WB).
// Optional retire counter is enabled by defining BITTY_RETIRE_CNT_EN.
module bitty_regfile_seq #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  input  logic [15:0]       inst,
  output logic              inst_ready,
  output logic [15:0]       inst_q,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  input  logic              alu_comp,
  input  logic              load_en,
  input  logic [2:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              carry_flag,
  output logic              comp_flag,
`ifdef BITTY_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic              done
);

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ST_W     = 2;

  localparam logic [ST_W-1:0] S_IDLE = 2'd0;
  localparam logic [ST_W-1:0] S_EXEC = 2'd1;
  localparam logic [ST_W-1:0] S_WB   = 2'd2;

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic              w_accept;
  logic              w_load;
  logic              w_wb;
  logic [2:0]        w_rx;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [15:0]       r_inst_q;
  logic              r_inst_ready;
  logic              r_carry;
  logic              r_comp;
  logic              r_done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = load_en;
        if (inst_valid && r_inst_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_WB;
      S_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rx = r_inst_q[15:13];

  // Ready tracks the next state so it is high exactly while in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_ready <= 1'b1;
      r_inst_q     <= '0;
      r_carry      <= 1'b0;
      r_comp       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inst_ready <= (w_state_nxt == S_IDLE);
      r_done       <= w_wb;
      if (w_accept) begin
        r_inst_q <= inst;
      end
      if (w_wb) begin
        r_carry <= alu_cout;
        r_comp  <= alu_comp;
      end
    end
  end

  // Preload (IDLE only) and writeback (WB only) never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb) begin
      r_regs[w_rx] <= alu_out;
    end else if (w_load) begin
      r_regs[load_addr] <= load_data;
    end
  end

`ifdef BITTY_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_wb) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

  assign inst_ready = r_inst_ready;
  assign inst_q     = r_inst_q;
  assign carry_flag = r_carry;
  assign comp_flag  = r_comp;
  assign done       = r_done;
  assign reg0       = r_regs[0];
  assign reg1       = r_regs[1];
  assign reg2       = r_regs[2];
  assign reg3       = r_regs[3];
  assign reg4       = r_regs[4];
  assign reg5       = r_regs[5];
  assign reg6       = r_regs[6];
  assign reg7       = r_regs[7];

endmodule

// File: tb/tb_bitty_regfile_seq.sv
// Directed bench for bitty_regfile_seq; inputs change and outputs are sampled on the falling edge.
module tb_bitty_regfile_seq;

  localparam int unsigned DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              inst_valid;
  logic [15:0]       inst;
  logic              inst_ready;
  logic [15:0]       inst_q;
  logic [DATA_W-1:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [DATA_W-1:0] alu_out;
  logic              alu_cout;
  logic              alu_comp;
  logic              load_en;
  logic [2:0]        load_addr;
  logic [DATA_W-1:0] load_data;
  logic              carry_flag;
  logic              comp_flag;
  logic              done;
`ifdef BITTY_RETIRE_CNT_EN
  logic [31:0]       retire_cnt;
`endif

  int n_tests;
  int n_fail;

  bitty_regfile_seq #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .inst_q     (inst_q),
    .reg0       (reg0),
    .reg1       (reg1),
    .reg2       (reg2),
    .reg3       (reg3),
    .reg4       (reg4),
    .reg5       (reg5),
    .reg6       (reg6),
    .reg7       (reg7),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_comp   (alu_comp),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .carry_flag (carry_flag),
    .comp_flag  (comp_flag),
`ifdef BITTY_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Accept one instruction and return at the falling edge after its writeback
  task automatic issue(input logic [15:0] i, input logic [15:0] r, input logic co, input logic cm);
    inst_valid = 1'b1;
    inst       = i;
    alu_out    = r;
    alu_cout   = co;
    alu_comp   = cm;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [8:0] done_pat;
  logic       done_seen;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    inst_valid = 1'b0;
    inst       = '0;
    alu_out    = '0;
    alu_cout   = 1'b0;
    alu_comp   = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_reg3", 32'(reg3), 32'h0);
    check("rst_ready", 32'(inst_ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_inst_q", 32'(inst_q), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload reg3 then retire inst 0x6000
    load_en = 1'b1; load_addr = 3'd3; load_data = 16'h1234;
    @(negedge clk);
    load_en = 1'b0;
    check("preload_reg3", 32'(reg3), 32'h1234);
    inst_valid = 1'b1; inst = 16'h6000; alu_out = 16'hBEEF; alu_cout = 1'b1; alu_comp = 1'b0;
    @(negedge clk);
    inst_valid = 1'b0;
    check("exec_ready", 32'(inst_ready), 32'h0);
    check("exec_inst_q", 32'(inst_q), 32'h6000);
    check("exec_reg3", 32'(reg3), 32'h1234);
    check("exec_done", 32'(done), 32'h0);
    @(negedge clk);
    check("wb_ready", 32'(inst_ready), 32'h0);
    check("wb_reg3", 32'(reg3), 32'h1234);
    @(negedge clk);
    check("ret_reg3", 32'(reg3), 32'hBEEF);
    check("ret_done", 32'(done), 32'h1);
    check("ret_carry", 32'(carry_flag), 32'h1);
    check("ret_comp", 32'(comp_flag), 32'h0);
    check("ret_ready", 32'(inst_ready), 32'h1);
    @(negedge clk);
    check("done_low", 32'(done), 32'h0);
    check("inst_q_hold", 32'(inst_q), 32'h6000);

    // Back-to-back with valid held: done every third cycle
    inst_valid = 1'b1; inst = 16'hE000; alu_out = 16'h0001; alu_cout = 1'b0; alu_comp = 1'b1;
    done_pat = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      done_pat = {done_pat[7:0], done};
    end
    inst_valid = 1'b0;
    check("b2b_done_pat", 32'(done_pat), 32'h049);
    check("b2b_reg7", 32'(reg7), 32'h0001);
    check("b2b_carry", 32'(carry_flag), 32'h0);
    check("b2b_comp", 32'(comp_flag), 32'h1);
    @(negedge clk);

    // Preload during EXEC is dropped; in IDLE it lands
    inst_valid = 1'b1; inst = 16'h2000; alu_out = 16'h5555;
    @(negedge clk);
    inst_valid = 1'b0;
    load_en = 1'b1; load_addr = 3'd5; load_data = 16'hAAAA;
    @(negedge clk);
    load_en = 1'b0;
    check("busy_reg5", 32'(reg5), 32'h0);
    @(negedge clk);
    check("busy_reg5_after", 32'(reg5), 32'h0);
    check("busy_reg1", 32'(reg1), 32'h5555);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check("idle_reg5", 32'(reg5), 32'hAAAA);

    // Preload and accept in the same cycle
    load_en = 1'b1; load_addr = 3'd2; load_data = 16'h0F0F;
    inst_valid = 1'b1; inst = 16'h4000; alu_out = 16'h1111; alu_cout = 1'b1; alu_comp = 1'b1;
    @(negedge clk);
    load_en = 1'b0; inst_valid = 1'b0;
    check("sim_exec_reg2", 32'(reg2), 32'h0F0F);
    @(negedge clk);
    check("sim_wb_reg2", 32'(reg2), 32'h0F0F);
    @(negedge clk);
    check("sim_ret_reg2", 32'(reg2), 32'h1111);
    check("sim_ret_done", 32'(done), 32'h1);
    @(negedge clk);

    // Reset mid-EXEC aborts the instruction
    inst_valid = 1'b1; inst = 16'h6000; alu_out = 16'hDEAD;
    @(negedge clk);
    inst_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_reg3", 32'(reg3), 32'h0);
    check("mid_rst_reg2", 32'(reg2), 32'h0);
    check("mid_rst_reg5", 32'(reg5), 32'h0);
    check("mid_rst_reg7", 32'(reg7), 32'h0);
    check("mid_rst_ready", 32'(inst_ready), 32'h1);
    check("mid_rst_flags", 32'({carry_flag, comp_flag}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    check("abort_no_done", 32'(done_seen), 32'h0);
    check("abort_no_wb", 32'(reg3), 32'h0);

`ifdef BITTY_RETIRE_CNT_EN
    for (int n = 0; n < 5; n++) issue(16'h0000, 16'(n), 1'b0, 1'b0);
    check("retire_cnt5", retire_cnt, 32'd5);
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    issue(16'h0000, 16'h0, 1'b0, 1'b0);
    check("retire_wrap", retire_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
